// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle main control unit and the datapath.
// The controller takes the master side; the datapath / instruction register takes the slave side.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state_out;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state_out, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state_out, illegal_op
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control unit: steps FETCH/DECODE/execute/writeback from the
// instruction-register opcode and decodes datapath controls from the current state.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic clk,
  input  logic rst,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  state_t state;
  state_t next_state;
  logic   illegal_q;
  logic   illegal_dispatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (illegal_dispatch)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state       = FETCH;
    illegal_dispatch = 1'b0;
    case (state)
      FETCH:     next_state = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW)
          next_state = MEM_ADDR;
        else if (bus.opcode == OP_RTYPE)
          next_state = EXECUTE;
        else if (bus.opcode == OP_BEQ)
          next_state = BRANCH;
        else if (bus.opcode == OP_J)
          next_state = JUMP;
        else if (bus.opcode == OP_ADDI)
          next_state = ADDI_EX;
        else begin
          next_state       = FETCH;
          illegal_dispatch = 1'b1;
        end
      end
      MEM_ADDR:  next_state = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  next_state = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: next_state = bus.mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   next_state = R_WB;
      ADDI_EX:   next_state = ADDI_WB;
      default:   next_state = FETCH;
    endcase
  end

  // Only the FETCH strobes look at mem_ready, so a stalled fetch never advances PC or IR.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    case (state)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE:    bus.alu_src_b = 2'b11;
      MEM_ADDR, ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      ADDI_WB:   bus.reg_write = 1'b1;
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.state_out  = state;
  assign bus.illegal_op = illegal_q;

endmodule
